fetch_queue: RTL

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_if.sv | 31 +++
 rtl/fetch_queue.sv | 97 +++++++++
 2 files changed

// File: rtl/fetch_queue_if.sv
// Fetch/decode boundary bundle for fetch_queue.
// The master modport is the queue; the slave modport is the environment
// (execute-stage redirect, decode stall, instruction memory).
// Handshake: a word moves from fetch into the queue whenever ImemReqF is 1,
// and leaves the queue whenever ValidD && !StallD.
interface fetch_queue_if #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
);
   logic                       PCSrcE;
   logic [XLEN-1:0]            PCTargetE;
   logic                       StallD;
   logic [XLEN-1:0]            ImemAddrF;
   logic                       ImemReqF;
   logic [XLEN-1:0]            ImemRdataF;
   logic [XLEN-1:0]            InstrD;
   logic [XLEN-1:0]            PCD;
   logic [XLEN-1:0]            PCPlus4D;
   logic                       ValidD;
   logic [$clog2(DEPTH):0]     CountQ;

   modport master (
      input  PCSrcE, PCTargetE, StallD, ImemRdataF,
      output ImemAddrF, ImemReqF, InstrD, PCD, PCPlus4D, ValidD, CountQ
   );

   modport slave (
      output PCSrcE, PCTargetE, StallD, ImemRdataF,
      input  ImemAddrF, ImemReqF, InstrD, PCD, PCPlus4D, ValidD, CountQ
   );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: PC generator feeding a circular buffer of
// {PC, instruction} entries, presented first-word fall-through to decode.
// A redirect flushes the queue and reloads the PC (word aligned); reset has
// priority over redirect.
// Optional macro FETCHQ_BYPASS_EN: when the queue is empty and decode is
// accepting, the freshly fetched word goes straight to decode in the same
// cycle instead of being written into the queue.
module fetch_queue #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic clk,
   input  logic reset,
   fetch_queue_if.master bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

   logic [XLEN-1:0] pc_f;
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic [XLEN-1:0] pc_mem    [DEPTH];
   logic [XLEN-1:0] instr_mem [DEPTH];

   logic full;
   logic empty;
   logic req;
   logic bypass;
   logic push;
   logic pop;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   // A pop freeing a slot does not open the queue for a push in the same cycle.
   assign req   = !reset && !full && !bus.PCSrcE;

`ifdef FETCHQ_BYPASS_EN
   assign bypass = req && empty && !bus.StallD;
`else
   assign bypass = 1'b0;
`endif

   assign push = req && !bypass;
   assign pop  = !reset && !empty && !bus.StallD && !bus.PCSrcE;

   // Decode-side view: head entry, bypassed word, or NOP when nothing is valid.
   always_comb begin
      bus.ImemAddrF = pc_f;
      bus.ImemReqF  = req;
      bus.CountQ    = reset ? '0 : count;
      bus.ValidD    = !reset && (!empty || bypass);
      bus.InstrD    = NOP;
      bus.PCD       = '0;
      if (!reset && !empty) begin
         bus.InstrD = instr_mem[rd_ptr];
         bus.PCD    = pc_mem[rd_ptr];
      end else if (bypass) begin
         bus.InstrD = bus.ImemRdataF;
         bus.PCD    = pc_f;
      end
      bus.PCPlus4D = bus.PCD + XLEN'(4);
   end

   // Entry storage: written at the write pointer on every push; no reset needed.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]    <= pc_f;
         instr_mem[wr_ptr] <= bus.ImemRdataF;
      end
   end

   // Fetch PC, pointers and occupancy: reset, then redirect, then push/pop.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_f   <= RESET_PC;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (bus.PCSrcE) begin
         pc_f   <= bus.PCTargetE & ~XLEN'(3);
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push || bypass) pc_f   <= pc_f + XLEN'(4);
         if (push)           wr_ptr <= wr_ptr + PW'(1);
         if (pop)            rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)
            count <= count + CW'(1);
         else if (pop && !push)
            count <= count - CW'(1);
      end
   end
endmodule
